// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker: verifies each accepted sample continues the
// sequence mod 2^DATA_WIDTH, reporting pass/fail pulses, a sticky error
// flag and a saturating count of matched terms.
module fibonacci_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter bit SEED_FREE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  restart,
  output logic                  pass,
  output logic                  fail,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  term_count,
  output logic [DATA_WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // awaiting term 1
    ST_SECOND = 2'd1,  // awaiting term 2
    ST_TRACK  = 2'd2,  // checking running sums
    ST_FAIL   = 2'd3   // halted after a mismatch
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
  // Value shown on expected while waiting for seeds; 0 is a don't-care
  // value when any seed is acceptable.
  localparam logic [DATA_WIDTH-1:0] SEED_EXP = SEED_FREE ? '0 : ONE;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] held_exp;
  logic [DATA_WIDTH-1:0] predict;
  logic                  match;
  logic                  take;

  // Carry out of the top bit is intentionally dropped: the generator wraps.
  assign sum = prev + cur;

  // A sample is consumed only when valid, not overridden by restart, and
  // the checker has not halted.
  assign take = din_valid && !restart && (state != ST_FAIL);

  // Decide whether the current sample is acceptable in the current state.
  always_comb begin
    match = 1'b0;
    case (state)
      ST_IDLE, ST_SECOND: match = SEED_FREE ? 1'b1 : (din == ONE);
      ST_TRACK:           match = (din == sum);
      default:            match = 1'b0;
    endcase
  end

  // State register; async reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; restart overrides any same-cycle sample.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = ST_IDLE;
    end else if (din_valid) begin
      case (state)
        ST_IDLE:   state_nxt = match ? ST_SECOND : ST_FAIL;
        ST_SECOND: state_nxt = match ? ST_TRACK  : ST_FAIL;
        ST_TRACK:  state_nxt = match ? ST_TRACK  : ST_FAIL;
        default:   state_nxt = ST_FAIL;
      endcase
    end
  end

  // Output logic: the value the checker would accept next. In FAIL it
  // freezes on whatever was expected when the mismatch happened.
  always_comb begin
    predict = SEED_EXP;
    case (state)
      ST_IDLE, ST_SECOND: predict = SEED_EXP;
      ST_TRACK:           predict = sum;
      default:            predict = held_exp;
    endcase
  end

  assign expected = predict;

  // Term history, result pulses, sticky error and saturating match count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      cur        <= '0;
      held_exp   <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      error      <= 1'b0;
      term_count <= '0;
    end else if (restart) begin
      prev       <= '0;
      cur        <= '0;
      held_exp   <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      error      <= 1'b0;
      term_count <= '0;
    end else begin
      pass <= 1'b0;
      fail <= 1'b0;
      if (take) begin
        if (match) begin
          pass <= 1'b1;
          cur  <= din;
          // The first seed has no predecessor to shift into prev.
          if (state != ST_IDLE) begin
            prev <= cur;
          end
          if (term_count != CNT_MAX) begin
            term_count <= term_count + CNT_WIDTH'(1);
          end
        end else begin
          // prev/cur stay put so the failing context remains observable.
          fail     <= 1'b1;
          error    <= 1'b1;
          held_exp <= predict;
        end
      end
    end
  end

  // Result pulses are mutually exclusive by construction.
  pulse_exclusive: assert property (@(posedge clk) disable iff (reset) !(pass && fail));

endmodule

// File: tb/tb_fibonacci_checker.sv
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  din8;

  logic        pass0, fail0, error0;
  logic [15:0] cnt0;
  logic [31:0] exp0;

  logic        pass8, fail8, error8;
  logic [15:0] cnt8;
  logic [7:0]  exp8;

  logic        passsf, failsf, errorsf;
  logic [3:0]  cntsf;
  logic [31:0] expsf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign din8 = din[7:0];

  fibonacci_checker #(.DATA_WIDTH(32), .CNT_WIDTH(16), .SEED_FREE(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .restart(restart),
    .pass(pass0), .fail(fail0), .error(error0), .term_count(cnt0), .expected(exp0)
  );

  fibonacci_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16), .SEED_FREE(1'b0)) u8 (
    .clk(clk), .reset(reset), .din(din8), .din_valid(din_valid), .restart(restart),
    .pass(pass8), .fail(fail8), .error(error8), .term_count(cnt8), .expected(exp8)
  );

  fibonacci_checker #(.DATA_WIDTH(32), .CNT_WIDTH(4), .SEED_FREE(1'b1)) usf (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .restart(restart),
    .pass(passsf), .fail(failsf), .error(errorsf), .term_count(cntsf), .expected(expsf)
  );

  typedef struct {
    logic        vld;
    logic        rs;
    logic [31:0] d;
    logic        p;
    logic        f;
    logic        e;
    logic [15:0] cnt;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Present one cycle of stimulus at the falling edge, then look at the
  // registered outputs just after the following rising edge.
  task automatic apply(input logic v, input logic r, input logic [31:0] d);
    @(negedge clk);
    din_valid = v;
    restart   = r;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    restart   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  wrap_seq[15];
    logic [31:0] sf_seq[20];
    logic [7:0]  w_exp;
    logic [31:0] sf_exp;
    logic [15:0] sf_cnt;

    wrap_seq = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

    sf_seq[0] = 32'd7;
    sf_seq[1] = 32'd3;
    for (int i = 2; i < 20; i++) sf_seq[i] = sf_seq[i-1] + sf_seq[i-2];

    // Main-path table for the 32-bit, fixed-seed checker.
    //            vld  rs    din     p     f     e     cnt     expected
    // generator stream
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 16'd1, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 16'd2, 32'd2});
    tbl.push_back('{1'b1, 1'b0, 32'd2,  1'b1, 1'b0, 1'b0, 16'd3, 32'd3});
    tbl.push_back('{1'b1, 1'b0, 32'd3,  1'b1, 1'b0, 1'b0, 16'd4, 32'd5});
    tbl.push_back('{1'b1, 1'b0, 32'd5,  1'b1, 1'b0, 1'b0, 16'd5, 32'd8});
    tbl.push_back('{1'b1, 1'b0, 32'd8,  1'b1, 1'b0, 1'b0, 16'd6, 32'd13});
    tbl.push_back('{1'b1, 1'b0, 32'd13, 1'b1, 1'b0, 1'b0, 16'd7, 32'd21});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 16'd7, 32'd21});
    tbl.push_back('{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 1'b0, 16'd0, 32'd1});
    // mismatch with gaps
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 16'd1, 32'd1});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 16'd1, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 16'd2, 32'd2});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 16'd2, 32'd2});
    tbl.push_back('{1'b1, 1'b0, 32'd2,  1'b1, 1'b0, 1'b0, 16'd3, 32'd3});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 16'd3, 32'd3});
    tbl.push_back('{1'b1, 1'b0, 32'd4,  1'b0, 1'b1, 1'b1, 16'd3, 32'd3});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 16'd3, 32'd3});
    tbl.push_back('{1'b1, 1'b0, 32'd6,  1'b0, 1'b0, 1'b1, 16'd3, 32'd3});
    tbl.push_back('{1'b1, 1'b1, 32'd1,  1'b0, 1'b0, 1'b0, 16'd0, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 16'd1, 32'd1});
    // bad first seed, then sample ignored while halted
    tbl.push_back('{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 1'b0, 16'd0, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd5,  1'b0, 1'b1, 1'b1, 16'd0, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b0, 1'b0, 1'b1, 16'd0, 32'd1});
    // bad second seed
    tbl.push_back('{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 1'b0, 16'd0, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 16'd1, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd7,  1'b0, 1'b1, 1'b1, 16'd1, 32'd1});
    tbl.push_back('{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 1'b0, 16'd0, 32'd1});

    // Reset values after a 3-cycle reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_fail", 32'(fail0), 32'd0);
    chk("rst_error", 32'(error0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_expected", exp0, 32'd1);
    chk("rst_expected_seedfree", expsf, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].vld, tbl[i].rs, tbl[i].d);
      chk($sformatf("vec%0d_pass", i), 32'(pass0), 32'(tbl[i].p));
      chk($sformatf("vec%0d_fail", i), 32'(fail0), 32'(tbl[i].f));
      chk($sformatf("vec%0d_error", i), 32'(error0), 32'(tbl[i].e));
      chk($sformatf("vec%0d_count", i), 32'(cnt0), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_expected", i), exp0, tbl[i].ex);
    end

    // Async reset between clock edges while tracking.
    apply(1'b1, 1'b0, 32'd1);
    apply(1'b1, 1'b0, 32'd1);
    apply(1'b1, 1'b0, 32'd2);
    chk("arst_pre_count", 32'(cnt0), 32'd3);
    chk("arst_pre_pass", 32'(pass0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pass", 32'(pass0), 32'd0);
    chk("arst_count", 32'(cnt0), 32'd0);
    chk("arst_error", 32'(error0), 32'd0);
    chk("arst_expected", exp0, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 1'b0, 32'd1);
    chk("arst_seed1_pass", 32'(pass0), 32'd1);
    apply(1'b1, 1'b0, 32'd1);
    chk("arst_seed2_pass", 32'(pass0), 32'd1);
    chk("arst_seed2_count", 32'(cnt0), 32'd2);
    chk("arst_seed2_expected", exp0, 32'd2);

    // 8-bit wrap-around.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apply(1'b1, 1'b0, 32'(wrap_seq[i]));
      w_exp = (i == 0) ? 8'd1 : 8'(wrap_seq[i] + wrap_seq[i-1]);
      chk($sformatf("wrap%0d_pass", i), 32'(pass8), 32'd1);
      chk($sformatf("wrap%0d_fail", i), 32'(fail8), 32'd0);
      chk($sformatf("wrap%0d_count", i), 32'(cnt8), 32'(i + 1));
      chk($sformatf("wrap%0d_expected", i), 32'(exp8), 32'(w_exp));
    end
    chk("wrap_final_expected", 32'(exp8), 32'd219);
    chk("wrap_final_error", 32'(error8), 32'd0);

    // Arbitrary seeds and count saturation at 4 bits.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b0, sf_seq[i]);
      sf_exp = (i == 0) ? 32'd0 : sf_seq[i] + sf_seq[i-1];
      sf_cnt = (i + 1 > 15) ? 16'd15 : 16'(i + 1);
      chk($sformatf("sf%0d_pass", i), 32'(passsf), 32'd1);
      chk($sformatf("sf%0d_fail", i), 32'(failsf), 32'd0);
      chk($sformatf("sf%0d_count", i), 32'(cntsf), 32'(sf_cnt));
      chk($sformatf("sf%0d_expected", i), expsf, sf_exp);
    end
    chk("sf_final_count", 32'(cntsf), 32'd15);
    chk("sf_final_error", 32'(errorsf), 32'd0);
    apply(1'b0, 1'b0, 32'd0);
    chk("sf_gap_pass", 32'(passsf), 32'd0);
    chk("sf_gap_count", 32'(cntsf), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
